reqack_sink: RTL and testbench
==============================

// Module: reqack_sink
// PURPOSE
//  Terminating responder for the 4-phase req/ack bundled-data protocol used by the pipeline stages.
//  - Accepts words from the last req/ack stage and buffers them in a DEPTH-entry FIFO.
//  - Presents the buffered words to local logic on a valid/ready interface.
//  - Completes the 4-phase handshake, applying back-pressure while the FIFO is full.
// PARAMETERS
//  DWIDTH  1  data path bit width (>=1)
//  DEPTH   2  FIFO entries; power of two, >=2
// PORTS
//  clk        in   1               rising-edge clock
//  rst_n      in   1               asynchronous reset, active low
//  req        in   1               request from upstream stage
//  ack        out  1               acknowledge to upstream stage
//  i_dat      in   DWIDTH          bundled data; stable from req rise until ack rise
//  o_valid    out  1               head-of-FIFO word available
//  o_ready    in   1               local consumer takes head word when o_valid & o_ready
//  o_dat      out  DWIDTH          head-of-FIFO word; don't-care while o_valid=0
//  level      out  $clog2(DEPTH)+1 number of stored words, 0..DEPTH
//  proto_err  out  1               sticky: req fell while ack=0
// BEHAVIOUR
//  - Reset values: ack=0, o_valid=0, level=0, proto_err=0, FSM=IDLE, FIFO pointers=0.
//    o_dat and FIFO storage are not reset.
//  - req_i: internal request.
//    - Without the CDC macro, req_i = req.
//    - With the CDC macro, req_i = req through a 2-flop synchronizer.
//    - A delay flop req_d on req_i provides fall detection.
//  - push = (FSM==IDLE) & req_i & (level<DEPTH); pop = o_valid & o_ready.
//  - FSM IDLE (ack=0):
//    - On push: i_dat is written at the write pointer, ack<=1, next state ACKED.
//    - If req_i=1 and level==DEPTH: stay in IDLE with ack=0 and wait (back-pressure).
//  - FSM ACKED (ack=1):
//    - When req_i=0: ack<=0, next state IDLE. No new word is accepted in that cycle.
//  - Latency, no CDC:
//    - req high before edge n: ack=1 and the word is stored after edge n.
//    - o_valid=1 after edge n if the FIFO was empty.
//    - req low before edge m: ack=0 after edge m.
//  - The full check uses the registered level only.
//    - When level==DEPTH, a pop in the same cycle does not enable a push.
//    - The push happens on the following cycle at the earliest.
//  - Simultaneous push and pop when 0<level<DEPTH: level unchanged; both pointers advance.
//  - Pointers are $clog2(DEPTH) bits and wrap from DEPTH-1 to 0. Full and empty are decided by level.
//  - Empty: o_valid=0; o_ready is ignored; pointers are not modified by o_ready.
//  - o_dat = storage[rd_ptr], combinational from the registered read pointer.
//  - proto_err:
//    - Set when req_d=1 & req_i=0 & ack=0 while FSM==IDLE.
//    - Stays set until reset.
//    - The FSM ignores the event.
//  - Assertions (simulation): no push when level==DEPTH; no pop when level==0; level<=DEPTH.
//  - Reset mid-operation:
//    - The FIFO is flushed and ack is forced to 0 immediately (asynchronous).
//    - The upstream stage must be reset together with this block.
// CONFIGURATION
//  - Macro REQACK_SINK_CDC_EN defined:
//    - A 2-flop synchronizer (reset to 0) is inserted on req.
//    - ack rises 2 cycles later than without the macro.
//    - Use when upstream is asynchronous to clk; i_dat must obey the bundled-data rule.
//  - Macro undefined: no synchronizer; req must be synchronous to clk.
// TESTING
//  - DEPTH=2, no CDC, req=1, i_dat=8'hA5, o_ready=0
//    -> after edge: ack=1, o_valid=1, o_dat=A5, level=1.
//    - then req=0 -> ack=0 after next edge.
//  - Fill with o_ready=0: two 4-phase transfers (11, 22) give level=2.
//    - A third req with data 33 is held with ack=0.
//    - Assert o_ready for 1 cycle -> 11 popped; the following cycle ack=1 and 33 is stored; level=2.
//  - o_ready=1 throughout with 8 back-to-back transfers 0..7:
//    - o_dat sequence is 0..7 in order, with no loss or duplication.
//    - Pointer wrap is exercised 4 times; level never exceeds 1.
//  - From IDLE, pulse req high for 1 cycle while held off because the FIFO is full
//    -> proto_err=1 and remains 1; level unchanged.
//  - Assert rst_n=0 mid-transfer with ack=1 and level=2
//    -> ack=0, o_valid=0, level=0, proto_err=0 immediately. A clean transfer works after release.
//  - With REQACK_SINK_CDC_EN, req rises before edge n -> ack=1 after edge n+2 and data is stored correctly.

Source files
------------

// File: rtl/reqack_sink.sv
// Terminating responder for the 4-phase req/ack bundled-data protocol: buffers words in a
// DEPTH-entry FIFO and exposes them on valid/ready. Define REQACK_SINK_CDC_EN to synchronize req.
module reqack_sink #(
    parameter int DWIDTH = 1,
    parameter int DEPTH  = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       req,
    output logic                       ack,
    input  logic [DWIDTH-1:0]          i_dat,
    output logic                       o_valid,
    input  logic                       o_ready,
    output logic [DWIDTH-1:0]          o_dat,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       proto_err
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    // Handshake contract: upstream raises req with i_dat stable; ack rises once the word is
    // stored; upstream drops req; ack drops. The local side moves a word when o_valid & o_ready.

    typedef enum logic {IDLE = 1'b0, ACKED = 1'b1} state_t;

    state_t            state_q, state_d;
    logic              req_i;
    logic              req_d;
    logic              push, pop;
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [DWIDTH-1:0] mem [DEPTH];

`ifdef REQACK_SINK_CDC_EN
    logic req_s1, req_s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_s1 <= 1'b0;
            req_s2 <= 1'b0;
        end else begin
            req_s1 <= req;
            req_s2 <= req_s1;
        end
    end

    assign req_i = req_s2;
`else
    assign req_i = req;
`endif

    // Full is judged on the registered level, so a same-cycle pop never frees a slot early.
    assign push    = (state_q == IDLE) && req_i && (level < FULL_LVL);
    assign o_valid = (level != '0);
    assign pop     = o_valid && o_ready;
    assign o_dat   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (push)   state_d = ACKED;
            ACKED:   if (!req_i) state_d = IDLE;
            default:             state_d = IDLE;
        endcase
    end

    always_comb begin
        ack = 1'b0;
        if (state_q == ACKED) ack = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_d     <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            req_d <= req_i;
            // A req withdrawn before it was acknowledged is a protocol violation.
            if (req_d && !req_i && !ack && (state_q == IDLE)) proto_err <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= i_dat;
    end

    a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && (level == FULL_LVL)));
    a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n)
        !(pop && (level == '0)));
    a_level_range: assert property (@(posedge clk) disable iff (!rst_n)
        level <= FULL_LVL);

endmodule

// File: tb/tb_reqack_sink.sv
// Directed bench for reqack_sink (DWIDTH=8, DEPTH=2) with a queue-based scoreboard on the
// valid/ready side; latency expectations follow REQACK_SINK_CDC_EN when it is defined.
module tb_reqack_sink;
    localparam int DW    = 8;
    localparam int DEPTH = 2;
`ifdef REQACK_SINK_CDC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic          clk;
    logic          rst_n;
    logic          req;
    logic          ack;
    logic [DW-1:0] i_dat;
    logic          o_valid;
    logic          o_ready;
    logic [DW-1:0] o_dat;
    logic [1:0]    level;
    logic          proto_err;

    logic [DW-1:0] exp_q[$];
    int            n_tests;
    int            n_fail;
    int            lvl_max;

    reqack_sink #(.DWIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .ack       (ack),
        .i_dat     (i_dat),
        .o_valid   (o_valid),
        .o_ready   (o_ready),
        .o_dat     (o_dat),
        .level     (level),
        .proto_err (proto_err)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // driver tasks
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input logic v, input string name);
        int k;
        k = 0;
        while (ack !== v && k < 40) begin
            tick(1);
            k++;
        end
        check(name, 32'(ack), 32'(v));
    endtask

    task automatic xfer(input logic [DW-1:0] d);
        i_dat = d;
        req   = 1'b1;
        exp_q.push_back(d);
        wait_ack(1'b1, "xfer_ack_rise");
        req = 1'b0;
        wait_ack(1'b0, "xfer_ack_fall");
    endtask

    task automatic drain(input int n);
        o_ready = 1'b1;
        tick(n);
        o_ready = 1'b0;
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (rst_n) begin
            if (32'(level) > lvl_max) lvl_max = 32'(level);
            if (o_valid && o_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pop", 32'(o_valid), 32'd0);
                end else begin
                    check("pop_data", 32'(o_dat), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        lvl_max = 0;
        rst_n   = 1'b0;
        req     = 1'b0;
        i_dat   = '0;
        o_ready = 1'b0;
        #3;
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_err", 32'(proto_err), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick(1);

        // single transfer with exact latency
        i_dat = 8'hA5;
        req   = 1'b1;
        exp_q.push_back(8'hA5);
        tick(1 + LAT);
        check("t1_ack_rise", 32'(ack), 32'd1);
        check("t1_valid", 32'(o_valid), 32'd1);
        check("t1_dat", 32'(o_dat), 32'hA5);
        check("t1_level", 32'(level), 32'd1);
        req = 1'b0;
        tick(1 + LAT);
        check("t1_ack_fall", 32'(ack), 32'd0);
        drain(1);
        check("t1_drained", 32'(level), 32'd0);

        // fill to DEPTH, then back-pressure and the one-cycle-late refill
        xfer(8'h11);
        xfer(8'h22);
        check("t2_full", 32'(level), 32'd2);
        i_dat = 8'h33;
        req   = 1'b1;
        exp_q.push_back(8'h33);
        tick(3 + LAT);
        check("t2_held_ack", 32'(ack), 32'd0);
        check("t2_held_level", 32'(level), 32'd2);
        o_ready = 1'b1;
        tick(1);
        o_ready = 1'b0;
        check("t2_pop_no_push_ack", 32'(ack), 32'd0);
        check("t2_pop_no_push_lvl", 32'(level), 32'd1);
        tick(1);
        check("t2_refill_ack", 32'(ack), 32'd1);
        check("t2_refill_level", 32'(level), 32'd2);
        req = 1'b0;
        wait_ack(1'b0, "t2_ack_fall");
        drain(2);
        check("t2_drained", 32'(level), 32'd0);

        // streaming with the consumer always ready; pointers wrap repeatedly
        o_ready = 1'b1;
        lvl_max = 0;
        for (int i = 0; i < 8; i++) xfer(8'(i));
        tick(3);
        o_ready = 1'b0;
        check("t3_level_max", 32'(lvl_max), 32'd1);
        check("t3_all_popped", 32'(exp_q.size()), 32'd0);
        check("t3_level_end", 32'(level), 32'd0);
        check("t3_no_err", 32'(proto_err), 32'd0);

        // req pulse while held off by a full FIFO flags a protocol error
        xfer(8'hAA);
        xfer(8'hBB);
        check("t4_full", 32'(level), 32'd2);
        i_dat = 8'hCC;
        req   = 1'b1;
        tick(1);
        req = 1'b0;
        tick(3 + LAT);
        check("t4_err_set", 32'(proto_err), 32'd1);
        check("t4_level", 32'(level), 32'd2);
        check("t4_ack", 32'(ack), 32'd0);
        tick(3);
        check("t4_err_sticky", 32'(proto_err), 32'd1);

        // asynchronous reset mid-transfer with ack high and FIFO full
        drain(1);
        check("t5_one_left", 32'(level), 32'd1);
        i_dat = 8'hCC;
        req   = 1'b1;
        exp_q.push_back(8'hCC);
        wait_ack(1'b1, "t5_ack_rise");
        check("t5_level_full", 32'(level), 32'd2);
        rst_n = 1'b0;
        #2;
        check("t5_rst_ack", 32'(ack), 32'd0);
        check("t5_rst_valid", 32'(o_valid), 32'd0);
        check("t5_rst_level", 32'(level), 32'd0);
        check("t5_rst_err", 32'(proto_err), 32'd0);
        exp_q.delete();
        req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick(1);
        xfer(8'h5A);
        drain(2);
        check("t5_post_level", 32'(level), 32'd0);
        check("t5_post_popped", 32'(exp_q.size()), 32'd0);

        // final report
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
